gray_sequencer: RTL

- Run-control controller for the Gray-code counter datapath.
- Accepts a 1-cycle step strobe from the clock divider, plus start/stop/pause commands.
- Sequences a WIDTH-bit count between 0 and a programmable limit, up or down, in one-shot or wrap mode.
- Drives the registered binary and Gray outputs and the status flags used by the top level and display logic.

---
 rtl/gray_pkg.sv | 24 ++
 rtl/gray_sequencer_if.sv | 29 ++
 rtl/gray_sequencer.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/gray_pkg.sv
// Shared types and helpers for the Gray-code run-control sequencer.
package gray_pkg;

  // FSM states; the encoding is visible on o_state.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } state_e;

  // Count direction as latched on start-load.
  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // Widest count the helper below handles; callers zero-extend and truncate.
  localparam int GRAY_MAX_W = 32;

  // Binary to reflected Gray code.
  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gray_sequencer_if.sv
// Command/status bundle between the run-control master and the sequencer.
interface gray_sequencer_if #(
  parameter int WIDTH = 4
);
  logic             tick;
  logic             start;
  logic             stop;
  logic             pause;
  logic             dir;
  logic             wrap;
  logic [WIDTH-1:0] limit;
  logic [WIDTH-1:0] bin;
  logic [WIDTH-1:0] gray;
  logic             running;
  logic             done;
  logic [1:0]       state;

  // Controller side: issues commands, observes status.
  modport master (
    output tick, start, stop, pause, dir, wrap, limit,
    input  bin, gray, running, done, state
  );

  // Sequencer side: receives commands, drives status.
  modport slave (
    input  tick, start, stop, pause, dir, wrap, limit,
    output bin, gray, running, done, state
  );
endinterface

// File: rtl/gray_sequencer.sv
// Run-control FSM and up/down counter with registered binary and Gray outputs.
module gray_sequencer
  import gray_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_tick,
  input  logic             i_start,
  input  logic             i_stop,
  input  logic             i_pause,
  input  logic             i_dir,
  input  logic             i_wrap,
  input  logic [WIDTH-1:0] i_limit,
  output logic [WIDTH-1:0] o_bin,
  output logic [WIDTH-1:0] o_gray,
  output logic             o_running,
  output logic             o_done,
  output logic [1:0]       o_state
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic             dir_q, dir_d;
  logic             wrap_q, wrap_d;
  logic             done_q, done_d;
  logic             running_q, running_d;

  logic [WIDTH-1:0] start_val;
  logic [WIDTH-1:0] end_val;

  // Start and end values of a pass follow from the latched direction.
  always_comb begin
    start_val = (dir_q == DIR_DOWN) ? limit_q : '0;
    end_val   = (dir_q == DIR_DOWN) ? '0 : limit_q;
  end

  // Next-state, next-count and output decode; priority stop > start > pause > tick.
  always_comb begin
    // NOTE: every signal gets a default here so no path through the case leaves it unassigned (which would infer a latch).
    state_d = state_q;
    count_d = count_q;
    limit_d = limit_q;
    dir_d   = dir_q;
    wrap_d  = wrap_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        count_d = '0;
        if (i_start) begin
          dir_d   = i_dir;
          wrap_d  = i_wrap;
          limit_d = i_limit;
          count_d = (i_dir == DIR_DOWN) ? i_limit : '0;
          state_d = RUN;
        end
      end

      RUN: begin
        // A start while running is a no-op and does not mask pause or tick.
        if (i_stop) begin
          state_d = IDLE;
          count_d = '0;
        end else if (i_pause) begin
          state_d = PAUSED;
        end else if (i_tick) begin
          if (count_q == end_val) begin
            done_d = 1'b1;
            if (wrap_q) count_d = start_val;
            else        state_d = DONE;
          end else if (dir_q == DIR_DOWN) begin
            count_d = count_q - WIDTH'(1);
          end else begin
            count_d = count_q + WIDTH'(1);
          end
        end
      end

      PAUSED: begin
        if (i_stop) begin
          state_d = IDLE;
          count_d = '0;
        end else if (i_start) begin
          state_d = RUN;
        end
      end

      DONE: begin
        if (i_stop) begin
          state_d = IDLE;
          count_d = '0;
        end else if (i_start) begin
          dir_d   = i_dir;
          wrap_d  = i_wrap;
          limit_d = i_limit;
          count_d = (i_dir == DIR_DOWN) ? i_limit : '0;
          state_d = RUN;
        end
      end

      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase

    // Gray and running are derived from next values so they register alongside.
    gray_d    = WIDTH'(bin2gray(GRAY_MAX_W'(count_d)));
    running_d = (state_d == RUN);
  end

  // State, count, latched config and registered outputs.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (i_rst) begin
      state_q   <= IDLE;
      count_q   <= '0;
      gray_q    <= '0;
      limit_q   <= '0;
      dir_q     <= 1'b0;
      wrap_q    <= 1'b0;
      done_q    <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      gray_q    <= gray_d;
      limit_q   <= limit_d;
      dir_q     <= dir_d;
      wrap_q    <= wrap_d;
      done_q    <= done_d;
      running_q <= running_d;
    end
  end

  assign o_bin     = count_q;
  assign o_gray    = gray_q;
  assign o_running = running_q;
  assign o_done    = done_q;
  assign o_state   = state_q;

endmodule
